// File: rtl/amax10_qsys_irq_pkg.sv
// Shared constants for the Avalon-MM interrupt aggregator: bus widths,
// register word addresses and the VECTOR register layout.
package amax10_qsys_irq_pkg;

  localparam int MAX_IRQ        = 16;
  localparam int DATA_W         = 16;
  localparam int ADDR_W         = 3;
  localparam int VECTOR_ANY_BIT = 15;
  localparam int VECTOR_IDX_W   = 4;

  localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_RAW     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_VECTOR  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_SWSET   = 3'd6;

endpackage

// File: rtl/amax10_qsys_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt aggregator register file.
interface amax10_qsys_irq_ctrl_if;
  import amax10_qsys_irq_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/amax10_qsys_irq_sync.sv
// Per-source input path: optional synchroniser flops, then the in_q/in_d
// pair that feeds the rising-edge detector. A rise is only reported once
// in_d holds a genuine post-reset sample, so a source that was already high
// across reset does not look like a fresh edge.
module amax10_qsys_irq_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_irq,
  output logic o_in_q,
  output logic o_rise
);

  localparam int PRIME_LEN = SYNC_STAGES + 2;

  logic                 w_sync;
  logic                 r_in_q;
  logic                 r_in_d;
  logic [PRIME_LEN-1:0] r_prime;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_sync = i_irq;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw source through the synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync <= '0;
      end else begin
        r_sync <= (r_sync << 1) | SYNC_STAGES'(i_irq);
      end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
  end

  // Capture the current and previous sample used by the edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_q <= 1'b0;
      r_in_d <= 1'b0;
    end else begin
      r_in_q <= w_sync;
      r_in_d <= r_in_q;
    end
  end

  // Fill with ones until in_d carries a real sample taken after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prime <= '0;
    end else begin
      r_prime <= {r_prime[PRIME_LEN-2:0], 1'b1};
    end
  end

  assign o_in_q = r_in_q;
  assign o_rise = r_in_q & ~r_in_d & r_prime[PRIME_LEN-1];

endmodule

// File: rtl/amax10_qsys_irq_ctrl.sv
// Avalon-MM interrupt aggregator: latches up to 16 sources as edge or level,
// masks them and drives one registered irq to the CPU. Registers follow the
// interval timer style: 16-bit data, 3-bit word address, registered readdata.
module amax10_qsys_irq_ctrl
  import amax10_qsys_irq_pkg::*;
#(
  parameter int                 NUM_IRQ     = 8,
  parameter int                 SYNC_STAGES = 0,
  parameter logic [MAX_IRQ-1:0] EDGE_RESET  = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  amax10_qsys_irq_ctrl_if.slave  bus,
  input  logic [NUM_IRQ-1:0]     irq_in,
  output logic                   irq
);

  logic [NUM_IRQ-1:0]      w_in_q;
  logic [NUM_IRQ-1:0]      w_rise;
  logic [NUM_IRQ-1:0]      r_pending;
  logic [NUM_IRQ-1:0]      r_mask;
  logic [NUM_IRQ-1:0]      r_edge;
  logic [NUM_IRQ-1:0]      w_active;
  logic [NUM_IRQ-1:0]      w_wdata;
  logic [NUM_IRQ-1:0]      w_w1c;
  logic [NUM_IRQ-1:0]      w_w1s;
  logic [NUM_IRQ-1:0]      w_edge_next;
  logic [NUM_IRQ-1:0]      w_pending_next;
  logic                    w_wr_base;
  logic                    w_wr_pending;
  logic                    w_wr_mask;
  logic                    w_wr_edge;
  logic                    w_wr_swset;
  logic                    w_vec_any;
  logic [VECTOR_IDX_W-1:0] w_vec_idx;
  logic [DATA_W-1:0]       w_pending_x;
  logic [DATA_W-1:0]       w_mask_x;
  logic [DATA_W-1:0]       w_edge_x;
  logic [DATA_W-1:0]       w_raw_x;
  logic [DATA_W-1:0]       w_active_x;
  logic [DATA_W-1:0]       w_vector;
  logic [DATA_W-1:0]       w_rd_mux;
  logic [DATA_W-1:0]       r_readdata;
  logic                    r_irq;
  logic                    w_unused_wdata;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
    amax10_qsys_irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_irq   (irq_in[gi]),
      .o_in_q  (w_in_q[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  // Upper writedata bits beyond NUM_IRQ have no backing register
  assign w_unused_wdata = ^bus.writedata;
  assign w_wdata        = bus.writedata[NUM_IRQ-1:0];

  assign w_wr_base    = bus.chipselect & ~bus.write_n;
  assign w_wr_pending = w_wr_base & (bus.address == ADDR_PENDING);
  assign w_wr_mask    = w_wr_base & (bus.address == ADDR_MASK);
  assign w_wr_edge    = w_wr_base & (bus.address == ADDR_EDGE);
  assign w_wr_swset   = w_wr_base & (bus.address == ADDR_SWSET);

  assign w_w1c = {NUM_IRQ{w_wr_pending}} & w_wdata;
  assign w_w1s = {NUM_IRQ{w_wr_swset}} & w_wdata;

  // Edge bits: a new rise or software set beats a simultaneous clear.
  // Level bits simply follow in_q, so W1C/SWSET cannot touch them.
  assign w_edge_next    = (r_pending & ~w_w1c) | w_rise | w_w1s;
  assign w_pending_next = (r_edge & w_edge_next) | (~r_edge & w_in_q);

  assign w_active = r_pending & r_mask;

  // Pending, mask and mode registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_edge    <= EDGE_RESET[NUM_IRQ-1:0];
    end else begin
      r_pending <= w_pending_next;
      if (w_wr_mask) begin
        r_mask <= w_wdata;
      end
      if (w_wr_edge) begin
        r_edge <= w_wdata;
      end
    end
  end

  // Registered aggregate interrupt to the CPU
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_active;
    end
  end

  // Lowest-index active source wins; scan from the top so index 0 lands last
  always_comb begin
    w_vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_vec_idx = VECTOR_IDX_W'(i);
      end
    end
  end

  assign w_vec_any = |w_active;

  // Zero-extend the per-source registers to the 16-bit bus view
  always_comb begin
    w_pending_x                 = '0;
    w_mask_x                    = '0;
    w_edge_x                    = '0;
    w_raw_x                     = '0;
    w_active_x                  = '0;
    w_vector                    = '0;
    w_pending_x[NUM_IRQ-1:0]    = r_pending;
    w_mask_x[NUM_IRQ-1:0]       = r_mask;
    w_edge_x[NUM_IRQ-1:0]       = r_edge;
    w_raw_x[NUM_IRQ-1:0]        = w_in_q;
    w_active_x[NUM_IRQ-1:0]     = w_active;
    w_vector[VECTOR_ANY_BIT]    = w_vec_any;
    w_vector[VECTOR_IDX_W-1:0]  = w_vec_idx;
  end

  // Read mux; SWSET and the spare address read as zero
  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_PENDING: w_rd_mux = w_pending_x;
      ADDR_MASK:    w_rd_mux = w_mask_x;
      ADDR_EDGE:    w_rd_mux = w_edge_x;
      ADDR_RAW:     w_rd_mux = w_raw_x;
      ADDR_ACTIVE:  w_rd_mux = w_active_x;
      ADDR_VECTOR:  w_rd_mux = w_vector;
      default:      w_rd_mux = '0;
    endcase
  end

  // Readdata is refreshed every cycle whether or not the slave is selected
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq;

endmodule
